// File: rtl/sram_request_responder_if.sv
// Request-side handshake between the ALU request registers and the SRAM responder.
// Signal names carry the responder's point of view (i_ = into responder, o_ = out of it).
interface sram_request_responder_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              i_trigger;
    logic              i_write_enable;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_data_in;
    logic              o_ready;
    logic              o_done;
    logic [DATA_W-1:0] o_data_read;

    modport master (
        output i_trigger,
        output i_write_enable,
        output i_address,
        output i_data_in,
        input  o_ready,
        input  o_done,
        input  o_data_read
    );

    modport slave (
        input  i_trigger,
        input  i_write_enable,
        input  i_address,
        input  i_data_in,
        output o_ready,
        output o_done,
        output o_data_read
    );
endinterface

// File: rtl/sram_request_responder.sv
// Single-word read/write sequencer for an asynchronous SRAM with programmable strobe width.
// Every pin, including the data-bus drive enable, comes straight from a register.
module sram_request_responder #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_request_responder_if.slave req,
    output logic [ADDR_W-1:0]    o_sram_addr,
    inout  wire  [DATA_W-1:0]    io_sram_data,
    output logic                 o_sram_ce,
    output logic                 o_sram_we,
    output logic                 o_sram_oe
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_op_write;
    logic [DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data_read;
    logic              r_ready;
    logic              r_done;
    logic              r_ce;
    logic              r_we;
    logic              r_oe;
    logic              r_bus_en;

    // Pin registers are set for the state being entered, so they change on the same edge as r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_op_write  <= 1'b0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_data_read <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_ce        <= 1'b1;
            r_we        <= 1'b1;
            r_oe        <= 1'b1;
            r_bus_en    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req.i_trigger) begin
                        r_op_write <= req.i_write_enable;
                        r_wdata    <= req.i_data_in;
                        r_addr     <= req.i_address;
                        r_ready    <= 1'b0;
                        r_ce       <= 1'b0;
                        r_bus_en   <= req.i_write_enable;
                        r_oe       <= req.i_write_enable;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    r_cnt   <= LP_CNT_LOAD;
                    r_we    <= ~r_op_write;
                    r_state <= STROBE;
                end
                STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_we    <= 1'b1;
                        r_oe    <= 1'b1;
                        r_state <= HOLD;
                        if (!r_op_write) begin
                            r_data_read <= io_sram_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    r_ce     <= 1'b1;
                    r_bus_en <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req.o_ready     = r_ready;
    assign req.o_done      = r_done;
    assign req.o_data_read = r_data_read;
    assign o_sram_addr     = r_addr;
    assign o_sram_ce       = r_ce;
    assign o_sram_we       = r_we;
    assign o_sram_oe       = r_oe;
    assign io_sram_data    = r_bus_en ? r_wdata : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_request_responder.sv
// Bench for sram_request_responder: vector table with per-cycle pin checks, a done-time
// scoreboard for oDataRead, async reset abort, and strobe-width checks at WAIT_CYCLES 1 and 15.
module tb_sram_request_responder;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- main DUT (WAIT_CYCLES = 2) ----------------
    sram_request_responder_if #(.ADDR_W(AW), .DATA_W(DW)) req ();
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic sram_ce, sram_we, sram_oe;

    sram_request_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req.slave),
        .o_sram_addr(sram_addr), .io_sram_data(sram_data),
        .o_sram_ce(sram_ce), .o_sram_we(sram_we), .o_sram_oe(sram_oe)
    );

    // Asynchronous SRAM model: 256 bytes addressed by the low address byte.
    logic [7:0] mem [256];
    assign sram_data = (!sram_ce && !sram_oe && sram_we) ? mem[sram_addr[7:0]] : 8'bz;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA0;
        forever begin
            @(posedge clk);
            if (!sram_ce && !sram_we) mem[sram_addr[7:0]] = sram_data;
        end
    end

    // ---------------- WAIT_CYCLES = 1 and 15 instances ----------------
    sram_request_responder_if #(.ADDR_W(AW), .DATA_W(DW)) req1 ();
    sram_request_responder_if #(.ADDR_W(AW), .DATA_W(DW)) req15 ();
    logic [AW-1:0] addr1, addr15;
    wire  [DW-1:0] data1, data15;
    logic ce1, we1, oe1, ce15, we15, oe15;

    sram_request_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1.slave),
        .o_sram_addr(addr1), .io_sram_data(data1),
        .o_sram_ce(ce1), .o_sram_we(we1), .o_sram_oe(oe1)
    );
    sram_request_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst), .req(req15.slave),
        .o_sram_addr(addr15), .io_sram_data(data15),
        .o_sram_ce(ce15), .o_sram_we(we15), .o_sram_oe(oe15)
    );
    assign data1  = (!ce1 && !oe1)   ? 8'h6D : 8'bz;
    assign data15 = (!ce15 && !oe15) ? 8'h6D : 8'bz;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Undriven bus reads as z in a 4-state simulator and 0 in a 2-state one.
    task automatic chk_z(input string name, input logic [DW-1:0] act);
        n_checks++;
        if (!((act === 8'bz) || (act === 8'h00))) begin
            n_errors++;
            $display("FAIL %s: got %h, expected high-Z", name, act);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] sb_q[$];
    int done_count = 0;
    logic [DW-1:0] last_read = 8'h00;

    always @(negedge clk) begin
        if (!rst && req.o_done) begin
            done_count++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [DW-1:0] exp;
                exp = sb_q.pop_front();
                chk("sb_data_read", 32'(req.o_data_read), 32'(exp));
                $display("done #%0d: data_read=%h expected=%h", done_count, req.o_data_read, exp);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_read;  // read result expected (reads only)
        bit            noise;     // toggle inputs/trigger while busy
        bit            hold;      // keep trigger high into the next request
    } vec_t;

    vec_t vecs[8];

    // Caller is at a negedge. Accept edge is E0; sample k is the negedge after edge E0+k.
    task automatic do_txn(input int idx, input vec_t v);
        int t;
        logic [4:0] exp_pins;
        string nm;
        t = 0;
        while (!req.o_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("v%0d_ready_wait", idx), 32'(req.o_ready), 32'd1);
        req.i_trigger      = 1'b1;
        req.i_write_enable = v.we;
        req.i_address      = v.addr;
        req.i_data_in      = v.data;
        if (v.we) begin
            sb_q.push_back(last_read);
        end else begin
            sb_q.push_back(v.exp_read);
            last_read = v.exp_read;
        end
        $display("txn %0d: %s addr=%h data=%h noise=%0d hold=%0d", idx, v.we ? "WR" : "RD",
                 v.addr, v.we ? v.data : v.exp_read, v.noise, v.hold);
        for (int k = 0; k <= W + 3; k++) begin
            @(negedge clk);
            // {ce, we, oe, done, ready}
            if (k == 0)           exp_pins = {1'b0, 1'b1, v.we, 2'b00};
            else if (k <= W)      exp_pins = {1'b0, !v.we, v.we, 2'b00};
            else if (k == W + 1)  exp_pins = 5'b01100;
            else if (k == W + 2)  exp_pins = 5'b11110;
            else                  exp_pins = 5'b11101;
            nm = $sformatf("v%0d_pins_k%0d", idx, k);
            chk(nm, 32'({sram_ce, sram_we, sram_oe, req.o_done, req.o_ready}), 32'(exp_pins));
            chk($sformatf("v%0d_addr_k%0d", idx, k), 32'(sram_addr), 32'(v.addr));
            nm = $sformatf("v%0d_bus_k%0d", idx, k);
            if (v.we && k <= W + 1)       chk(nm, 32'(sram_data), 32'(v.data));
            else if (!v.we && k <= W)     chk(nm, 32'(sram_data), 32'(v.exp_read));
            else                          chk_z(nm, sram_data);
            if (!v.hold) begin
                if (k < W + 3 && v.noise) begin
                    req.i_trigger      = 1'($urandom_range(0, 1));
                    req.i_write_enable = 1'($urandom_range(0, 1));
                    req.i_address      = 19'($urandom);
                    req.i_data_in      = 8'($urandom);
                end else begin
                    req.i_trigger = 1'b0;
                end
            end
        end
    endtask

    int oe_cnt1, oe_cnt15, done_k1, done_k15;

    initial begin
        req.i_trigger = 1'b0; req.i_write_enable = 1'b0; req.i_address = '0; req.i_data_in = '0;
        req1.i_trigger = 1'b0; req1.i_write_enable = 1'b0; req1.i_address = 19'h00100; req1.i_data_in = 8'h00;
        req15.i_trigger = 1'b0; req15.i_write_enable = 1'b0; req15.i_address = 19'h00200; req15.i_data_in = 8'h00;

        vecs[0] = '{we: 1'b1, addr: 19'h000A5, data: 8'h3C, exp_read: 8'h00, noise: 1'b0, hold: 1'b0};
        vecs[1] = '{we: 1'b0, addr: 19'h000A5, data: 8'hC3, exp_read: 8'h3C, noise: 1'b0, hold: 1'b0};
        vecs[2] = '{we: 1'b1, addr: 19'h40012, data: 8'h5A, exp_read: 8'h00, noise: 1'b1, hold: 1'b0};
        vecs[3] = '{we: 1'b0, addr: 19'h40012, data: 8'hA5, exp_read: 8'h5A, noise: 1'b1, hold: 1'b0};
        vecs[4] = '{we: 1'b1, addr: 19'h000A5, data: 8'h81, exp_read: 8'h00, noise: 1'b0, hold: 1'b1};
        vecs[5] = '{we: 1'b0, addr: 19'h000A5, data: 8'h7E, exp_read: 8'h81, noise: 1'b0, hold: 1'b0};
        vecs[6] = '{we: 1'b0, addr: 19'h7FF33, data: 8'h6C, exp_read: 8'h93, noise: 1'b1, hold: 1'b0};
        vecs[7] = '{we: 1'b1, addr: 19'h00040, data: 8'h11, exp_read: 8'h00, noise: 1'b1, hold: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pins", 32'({req.o_ready, req.o_done, sram_ce, sram_we, sram_oe}), 32'(5'b10111));
        chk("rst_data_read", 32'(req.o_data_read), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk_z("rst_bus", sram_data);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_txn(i, vecs[i]);
        req.i_trigger = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_count), 32'd8);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("addr_held_after_done", 32'(sram_addr), 32'h00040);
        chk("data_read_after_write", 32'(req.o_data_read), 32'h93);

        // Asynchronous reset in the middle of a write strobe
        req.i_trigger = 1'b1; req.i_write_enable = 1'b1; req.i_address = 19'h00077; req.i_data_in = 8'hE7;
        @(negedge clk);
        req.i_trigger = 1'b0;
        @(negedge clk);
        chk("abort_in_strobe", 32'({sram_ce, sram_we, sram_oe}), 32'(3'b001));
        #2 rst = 1'b1;
        #1;
        chk("abort_pins_async", 32'({sram_ce, sram_we, sram_oe, req.o_done}), 32'(4'b1110));
        chk_z("abort_bus_async", sram_data);
        chk("abort_ready_async", 32'(req.o_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        last_read = 8'h00;
        repeat (8) @(negedge clk);
        chk("abort_no_done", 32'(done_count), 32'd8);
        chk("abort_ready_after", 32'(req.o_ready), 32'd1);
        chk("abort_data_read", 32'(req.o_data_read), 32'd0);
        $display("abort: done_count=%0d ready=%0d", done_count, req.o_ready);

        // Strobe width at WAIT_CYCLES = 1 and 15 (reads)
        oe_cnt1 = 0; oe_cnt15 = 0; done_k1 = -1; done_k15 = -1;
        req1.i_trigger = 1'b1; req15.i_trigger = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            req1.i_trigger = 1'b0; req15.i_trigger = 1'b0;
            if (!oe1)  oe_cnt1++;
            if (!oe15) oe_cnt15++;
            if (req1.o_done && done_k1 < 0)   done_k1 = k;
            if (req15.o_done && done_k15 < 0) done_k15 = k;
        end
        $display("wait1: oe_low=%0d done_k=%0d  wait15: oe_low=%0d done_k=%0d", oe_cnt1, done_k1, oe_cnt15, done_k15);
        chk("w1_oe_low", 32'(oe_cnt1), 32'd2);
        chk("w1_done_k", 32'(done_k1), 32'd3);
        chk("w1_data_read", 32'(req1.o_data_read), 32'h6D);
        chk("w15_oe_low", 32'(oe_cnt15), 32'd16);
        chk("w15_done_k", 32'(done_k15), 32'd17);
        chk("w15_data_read", 32'(req15.o_data_read), 32'h6D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
